md_divider: RTL and testbench

MD_DIVIDER -- requirements
Module: md_divider

---
 rtl/md_divider_if.sv | 20 ++
 rtl/md_divider.sv | 124 ++++++++++++
 tb/tb_md_divider.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/md_divider_if.sv
// Request/response bundle for md_divider: operands and op code in, busy/valid/result out.
interface md_divider_if;
    logic        i_start;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic [1:0]  i_div_op;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    modport master (
        output i_start, i_op_a, i_op_b, i_div_op,
        input  o_busy, o_valid, o_result
    );

    modport slave (
        input  i_start, i_op_a, i_op_b, i_div_op,
        output o_busy, o_valid, o_result
    );
endinterface

// File: rtl/md_divider.sv
// 32-bit iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module md_divider (
    input logic         i_clk,
    input logic         i_rst,
    md_divider_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;       // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic        is_rem_q, is_rem_d;
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;

    logic        accept, signed_op, a_neg, b_neg, div_zero, overflow;
    logic [31:0] a_mag, b_mag, special_res;
    logic [32:0] rem_shift, diff;
    logic        q_bit;
    logic [31:0] rem_step, dvd_step, final_res;

    always_comb begin
        accept    = (state_q != StCalc) && bus.i_start;
        signed_op = ~bus.i_div_op[0];
        a_neg     = signed_op & bus.i_op_a[31];
        b_neg     = signed_op & bus.i_op_b[31];
        a_mag     = a_neg ? (~bus.i_op_a + 32'd1) : bus.i_op_a;
        b_mag     = b_neg ? (~bus.i_op_b + 32'd1) : bus.i_op_b;
        div_zero  = (bus.i_op_b == 32'd0);
        overflow  = signed_op && (bus.i_op_a == 32'h8000_0000) && (bus.i_op_b == 32'hFFFF_FFFF);
        if (div_zero) begin
            special_res = bus.i_div_op[1] ? bus.i_op_a : 32'hFFFF_FFFF;
        end else begin
            special_res = bus.i_div_op[1] ? 32'd0 : 32'h8000_0000;
        end

        // rem_q < divisor, so the 33-bit difference sign is a valid compare result.
        rem_shift = {rem_q, dvd_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        q_bit     = ~diff[32];
        rem_step  = q_bit ? diff[31:0] : rem_shift[31:0];
        dvd_step  = {dvd_q[30:0], q_bit};
        if (is_rem_q) begin
            final_res = rem_neg_q ? (~rem_step + 32'd1) : rem_step;
        end else begin
            final_res = quot_neg_q ? (~dvd_step + 32'd1) : dvd_step;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        result_d   = result_q;
        is_rem_d   = is_rem_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    is_rem_d   = bus.i_div_op[1];
                    quot_neg_d = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = 32'd0;
                        cnt_d   = 5'd0;
                        state_d = StCalc;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = final_res;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rem_q      <= 32'd0;
            result_q   <= 32'd0;
            is_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            is_rem_q   <= is_rem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    assign bus.o_busy   = (state_q == StCalc);
    assign bus.o_valid  = (state_q == StDone);
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_md_divider.sv
// Self-checking bench for md_divider: vector table, scoreboard queue, and
// hand-written sequences for ignored start, mid-operation reset and back-to-back ops.
module tb_md_divider;
    localparam logic [1:0] OpDiv  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRem  = 2'b10;
    localparam logic [1:0] OpRemu = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    md_divider_if bus ();

    md_divider dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_start  = 1'b1;
        bus.i_div_op = op;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
    endtask

    // Scramble operands after acceptance; the latched values must be used.
    task automatic idle_inputs();
        bus.i_start  = 1'b0;
        bus.i_op_a   = $urandom;
        bus.i_op_b   = $urandom;
        bus.i_div_op = 2'($urandom_range(3, 0));
    endtask

    // Called right after the accepting edge; returns at the negedge where o_valid is seen.
    task automatic collect(input string name, input int lat_exp);
        int   cyc = 0;
        int   busy = 0;
        bit   seen = 0;
        logic [31:0] exp;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) idle_inputs();
            if (bus.o_valid) begin
                seen = 1;
                cyc  = i;
            end else begin
                if (bus.o_busy) busy++;
                @(posedge clk);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no valid want valid within 40 cycles", name);
            return;
        end
        check({name, " latency"}, 32'(cyc), 32'(lat_exp));
        check({name, " busy cycles"}, 32'(busy), (lat_exp == 33) ? 32'd32 : 32'd0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: got result %h want none pending", name, bus.o_result);
        end else begin
            exp = exp_q.pop_front();
            check({name, " result"}, bus.o_result, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat);
        @(negedge clk);
        drive_start(op, a, b);
        exp_q.push_back(res);
        @(posedge clk);
        collect(name, lat);
        @(posedge clk);
        @(negedge clk);
        check({name, " single pulse"}, {31'd0, bus.o_valid}, 32'd0);
        check({name, " hold"}, bus.o_result, res);
    endtask

    initial begin
        int pulses;
        int first_cyc;

        vecs.push_back(vec_t'{OpDivu, 32'd100, 32'd7, 32'd14, 33});
        vecs.push_back(vec_t'{OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
        vecs.push_back(vec_t'{OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
        vecs.push_back(vec_t'{OpDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back(vec_t'{OpRemu, 32'd5, 32'd0, 32'd5, 1});
        vecs.push_back(vec_t'{OpRem, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1});
        vecs.push_back(vec_t'{OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back(vec_t'{OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
        vecs.push_back(vec_t'{OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33});
        vecs.push_back(vec_t'{OpRemu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back(vec_t'{OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
        vecs.push_back(vec_t'{OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33});
        vecs.push_back(vec_t'{OpDiv, 32'h8000_0000, 32'd2, 32'hC000_0000, 33});
        vecs.push_back(vec_t'{OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33});
        vecs.push_back(vec_t'{OpRemu, 32'hFFFF_FFFF, 32'd16, 32'd15, 33});
        vecs.push_back(vec_t'{OpDivu, 32'd0, 32'd5, 32'd0, 33});

        // Reset held with a simultaneous start: nothing may be accepted.
        drive_start(OpDiv, 32'd5, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, bus.o_busy}, 32'd0);
        check("reset valid", {31'd0, bus.o_valid}, 32'd0);
        check("reset result", bus.o_result, 32'd0);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check("start under reset ignored", {31'd0, bus.o_valid}, 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].lat);
        end

        // Start while busy must be ignored.
        @(negedge clk);
        drive_start(OpDivu, 32'd100, 32'd7);
        exp_q.push_back(32'd14);
        @(posedge clk);
        pulses    = 0;
        first_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1 || i == 6) idle_inputs();
            if (i == 5) drive_start(OpDivu, 32'd50, 32'd5);
            if (bus.o_valid) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = i;
                    check("busy start result", bus.o_result, exp_q.pop_front());
                end
            end
            @(posedge clk);
        end
        check("busy start pulses", 32'(pulses), 32'd1);
        check("busy start latency", 32'(first_cyc), 32'd33);

        // Reset in the middle of an operation aborts it silently.
        @(negedge clk);
        drive_start(OpDivu, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid busy before reset", {31'd0, bus.o_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, bus.o_busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        check("abort no valid", 32'(pulses), 32'd0);
        run_op("after abort", OpDivu, 32'd9, 32'd3, 32'd3, 33);

        // Back-to-back: new start accepted in DONE with no idle cycle.
        @(negedge clk);
        drive_start(OpDiv, 32'd5, 32'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        @(posedge clk);
        collect("b2b first", 1);
        drive_start(OpDivu, 32'd100, 32'd7);
        exp_q.push_back(32'd14);
        @(posedge clk);
        collect("b2b second", 33);
        @(posedge clk);
        @(negedge clk);
        check("b2b single pulse", {31'd0, bus.o_valid}, 32'd0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
